// File: rtl/frame_stats_unit.sv
// Per-frame pixel statistics: count, sum, min, max and bright-pixel count,
// committed at frame end into a record register offered on a valid/ready port.
module frame_stats_unit #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pixel_in,
  input  logic             pixel_valid,
  input  logic             frame_start,
  input  logic             frame_done,
  input  logic [7:0]       threshold,
  input  logic             overrun_clr,
  output logic             stats_valid,
  input  logic             stats_ready,
  output logic [CNT_W-1:0] pix_count,
  output logic [SUM_W-1:0] pix_sum,
  output logic [7:0]       pix_min,
  output logic [7:0]       pix_max,
  output logic [CNT_W-1:0] bright_count,
  output logic             saturated,
  output logic             overrun,
  output logic             busy
);

  // Output handshake: a record moves on any posedge where stats_valid && stats_ready.
  // stats_valid never drops without a transfer, and record fields hold while it is high.

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, bright_q, bright_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       min_q, min_d, max_q, max_d, thr_q, thr_d;
  logic             sat_q, sat_d;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d, rbright_q, rbright_d;
  logic [SUM_W-1:0] rsum_q, rsum_d;
  logic [7:0]       rmin_q, rmin_d, rmax_q, rmax_d;
  logic             rsat_q, rsat_d;
  logic             overrun_q, overrun_d;

  logic             restart, commit, transfer, load, drop;
  logic [CNT_W-1:0] base_cnt, base_bright, inc_cnt, inc_bright;
  logic [SUM_W-1:0] base_sum, inc_sum;
  logic [SUM_W:0]   sum_wide;
  logic [7:0]       base_min, base_max, inc_min, inc_max, thr_use;
  logic             base_sat, inc_sat;

  // Accumulator update including this cycle's pixel. On a restart the base is
  // the cleared frame and the freshly presented threshold applies.
  always_comb begin
    restart     = frame_start && ((state_q == S_IDLE) || !frame_done);
    commit      = (state_q == S_ACCUM) && frame_done;
    base_cnt    = restart ? '0 : cnt_q;
    base_sum    = restart ? '0 : sum_q;
    base_bright = restart ? '0 : bright_q;
    base_min    = restart ? 8'hFF : min_q;
    base_max    = restart ? 8'h00 : max_q;
    base_sat    = restart ? 1'b0 : sat_q;
    thr_use     = restart ? threshold : thr_q;
    sum_wide    = {1'b0, base_sum} + {{(SUM_W-7){1'b0}}, pixel_in};

    inc_cnt    = base_cnt;
    inc_sum    = base_sum;
    inc_bright = base_bright;
    inc_min    = base_min;
    inc_max    = base_max;
    inc_sat    = base_sat;
    if (pixel_valid) begin
      if (base_cnt == '1) inc_sat = 1'b1;
      else inc_cnt = base_cnt + CNT_W'(1);
      if (sum_wide[SUM_W]) begin
        inc_sum = '1;
        inc_sat = 1'b1;
      end else begin
        inc_sum = sum_wide[SUM_W-1:0];
      end
      if (pixel_in < base_min) inc_min = pixel_in;
      if (pixel_in > base_max) inc_max = pixel_in;
      if (pixel_in >= thr_use) begin
        if (base_bright == '1) inc_sat = 1'b1;
        else inc_bright = base_bright + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    bright_d = bright_q;
    min_d    = min_q;
    max_d    = max_q;
    sat_d    = sat_q;
    thr_d    = thr_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d  = S_ACCUM;
          cnt_d    = inc_cnt;
          sum_d    = inc_sum;
          bright_d = inc_bright;
          min_d    = inc_min;
          max_d    = inc_max;
          sat_d    = inc_sat;
          thr_d    = threshold;
        end
      end
      S_ACCUM: begin
        if (frame_done) begin
          // The same-cycle pixel belongs to the committed record, so a
          // back-to-back frame_start opens an empty frame.
          if (frame_start) begin
            cnt_d    = '0;
            sum_d    = '0;
            bright_d = '0;
            min_d    = 8'hFF;
            max_d    = 8'h00;
            sat_d    = 1'b0;
            thr_d    = threshold;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d    = inc_cnt;
          sum_d    = inc_sum;
          bright_d = inc_bright;
          min_d    = inc_min;
          max_d    = inc_max;
          sat_d    = inc_sat;
          if (frame_start) thr_d = threshold;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    transfer  = valid_q && stats_ready;
    load      = commit && (!valid_q || transfer);
    drop      = commit && valid_q && !stats_ready;
    valid_d   = valid_q;
    rcnt_d    = rcnt_q;
    rsum_d    = rsum_q;
    rbright_d = rbright_q;
    rmin_d    = rmin_q;
    rmax_d    = rmax_q;
    rsat_d    = rsat_q;
    if (load) begin
      valid_d   = 1'b1;
      rcnt_d    = inc_cnt;
      rsum_d    = inc_sum;
      rbright_d = inc_bright;
      rmin_d    = inc_min;
      rmax_d    = inc_max;
      rsat_d    = inc_sat;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (drop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      bright_q  <= '0;
      min_q     <= '0;
      max_q     <= '0;
      sat_q     <= 1'b0;
      thr_q     <= '0;
      valid_q   <= 1'b0;
      rcnt_q    <= '0;
      rsum_q    <= '0;
      rbright_q <= '0;
      rmin_q    <= '0;
      rmax_q    <= '0;
      rsat_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      bright_q  <= bright_d;
      min_q     <= min_d;
      max_q     <= max_d;
      sat_q     <= sat_d;
      thr_q     <= thr_d;
      valid_q   <= valid_d;
      rcnt_q    <= rcnt_d;
      rsum_q    <= rsum_d;
      rbright_q <= rbright_d;
      rmin_q    <= rmin_d;
      rmax_q    <= rmax_d;
      rsat_q    <= rsat_d;
      overrun_q <= overrun_d;
    end
  end

  assign stats_valid  = valid_q;
  assign pix_count    = rcnt_q;
  assign pix_sum      = rsum_q;
  assign pix_min      = rmin_q;
  assign pix_max      = rmax_q;
  assign bright_count = rbright_q;
  assign saturated    = rsat_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == S_ACCUM);

endmodule

// File: tb/tb_frame_stats_unit.sv
// Directed bench for frame_stats_unit: default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_frame_stats_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel_in;
  logic        pixel_valid, frame_start, frame_done, overrun_clr, stats_ready;
  logic [7:0]  threshold;

  logic        stats_valid, saturated, overrun, busy;
  logic [15:0] pix_count, bright_count;
  logic [23:0] pix_sum;
  logic [7:0]  pix_min, pix_max;

  logic        stats_valid4, saturated4, overrun4, busy4;
  logic [3:0]  pix_count4, bright_count4;
  logic [23:0] pix_sum4;
  logic [7:0]  pix_min4, pix_max4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_stats_unit dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .frame_done(frame_done), .threshold(threshold),
    .overrun_clr(overrun_clr), .stats_valid(stats_valid), .stats_ready(stats_ready),
    .pix_count(pix_count), .pix_sum(pix_sum), .pix_min(pix_min), .pix_max(pix_max),
    .bright_count(bright_count), .saturated(saturated), .overrun(overrun), .busy(busy)
  );

  frame_stats_unit #(.CNT_W(4), .SUM_W(24)) dut4 (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .frame_done(frame_done), .threshold(threshold),
    .overrun_clr(overrun_clr), .stats_valid(stats_valid4), .stats_ready(stats_ready),
    .pix_count(pix_count4), .pix_sum(pix_sum4), .pix_min(pix_min4), .pix_max(pix_max4),
    .bright_count(bright_count4), .saturated(saturated4), .overrun(overrun4), .busy(busy4)
  );

  // Inputs change 1 time unit after posedge; checks happen at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] thr);
    frame_start = 1'b1;
    threshold   = thr;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] p);
    pixel_valid = 1'b1;
    pixel_in    = p;
    cycle();
    pixel_valid = 1'b0;
  endtask

  task automatic end_frame();
    frame_done = 1'b1;
    cycle();
    frame_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pixel_in = '0; pixel_valid = 1'b0; frame_start = 1'b0;
    frame_done = 1'b0; threshold = '0; overrun_clr = 1'b0; stats_ready = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    checks++; if (stats_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", stats_valid); end
    checks++; if (pix_min !== 8'h00) begin errors++; $display("FAIL reset_min got %0h exp 00", pix_min); end
    checks++; if ({pix_count, pix_sum, pix_max, bright_count} !== 64'd0) begin errors++; $display("FAIL reset_fields got %0h exp 0", {pix_count, pix_sum, pix_max, bright_count}); end
    checks++; if ({saturated, overrun, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {saturated, overrun, busy}); end
  endtask

  task automatic test_basic();
    stats_ready = 1'b1;
    start_frame(8'd128);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %0b exp 1", busy); end
    send_pixel(8'd10); send_pixel(8'd200); send_pixel(8'd50); send_pixel(8'd130);
    end_frame();
    checks++; if (stats_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0b exp 1", stats_valid); end
    checks++; if (pix_count !== 16'd4) begin errors++; $display("FAIL t1_count got %0d exp 4", pix_count); end
    checks++; if (pix_sum !== 24'd390) begin errors++; $display("FAIL t1_sum got %0d exp 390", pix_sum); end
    checks++; if (pix_min !== 8'd10 || pix_max !== 8'd200) begin errors++; $display("FAIL t1_minmax got %0d/%0d exp 10/200", pix_min, pix_max); end
    checks++; if (bright_count !== 16'd2) begin errors++; $display("FAIL t1_bright got %0d exp 2", bright_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle got %0b exp 0", busy); end
    cycle();
    checks++; if (stats_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop got %0b exp 0", stats_valid); end
  endtask

  task automatic test_overrun();
    stats_ready = 1'b0;
    start_frame(8'd2);
    send_pixel(8'd1); send_pixel(8'd2); send_pixel(8'd3);
    end_frame();
    start_frame(8'd0);
    send_pixel(8'd100);
    end_frame();
    checks++; if (stats_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got %0b exp 1", stats_valid); end
    checks++; if (pix_count !== 16'd3 || pix_sum !== 24'd6) begin errors++; $display("FAIL t2_held got %0d/%0d exp 3/6", pix_count, pix_sum); end
    checks++; if (pix_min !== 8'd1 || pix_max !== 8'd3 || bright_count !== 16'd2) begin errors++; $display("FAIL t2_held2 got %0d/%0d/%0d exp 1/3/2", pix_min, pix_max, bright_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t2_overrun got %0b exp 1", overrun); end
    cycle();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t2_sticky got %0b exp 1", overrun); end
    overrun_clr = 1'b1;
    cycle();
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t2_clr got %0b exp 0", overrun); end
    stats_ready = 1'b1;
    cycle();
    checks++; if (stats_valid !== 1'b0) begin errors++; $display("FAIL t2_drain got %0b exp 0", stats_valid); end
  endtask

  task automatic test_empty();
    start_frame(8'd0);
    end_frame();
    checks++; if (stats_valid !== 1'b1) begin errors++; $display("FAIL t3_valid got %0b exp 1", stats_valid); end
    checks++; if (pix_count !== 16'd0 || pix_sum !== 24'd0 || bright_count !== 16'd0) begin errors++; $display("FAIL t3_zero got %0d/%0d/%0d exp 0/0/0", pix_count, pix_sum, bright_count); end
    checks++; if (pix_min !== 8'hFF || pix_max !== 8'h00) begin errors++; $display("FAIL t3_minmax got %0h/%0h exp ff/00", pix_min, pix_max); end
    checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL t3_sat got %0b exp 0", saturated); end
    cycle();
  endtask

  task automatic test_saturation();
    start_frame(8'hFF);
    for (int i = 0; i < 20; i++) send_pixel(8'hFF);
    end_frame();
    checks++; if (stats_valid4 !== 1'b1) begin errors++; $display("FAIL t4_valid got %0b exp 1", stats_valid4); end
    checks++; if (pix_count4 !== 4'd15 || bright_count4 !== 4'd15) begin errors++; $display("FAIL t4_count got %0d/%0d exp 15/15", pix_count4, bright_count4); end
    checks++; if (saturated4 !== 1'b1) begin errors++; $display("FAIL t4_sat got %0b exp 1", saturated4); end
    checks++; if (pix_sum4 !== 24'd5100) begin errors++; $display("FAIL t4_sum got %0d exp 5100", pix_sum4); end
    checks++; if (pix_count !== 16'd20 || bright_count !== 16'd20 || saturated !== 1'b0) begin errors++; $display("FAIL t4_wide got %0d/%0d/%0b exp 20/20/0", pix_count, bright_count, saturated); end
    cycle();
  endtask

  task automatic test_restart();
    start_frame(8'd6);
    send_pixel(8'd1); send_pixel(8'd2); send_pixel(8'd3);
    frame_start = 1'b1; threshold = 8'd6; pixel_valid = 1'b1; pixel_in = 8'd5;
    cycle();
    frame_start = 1'b0;
    frame_done = 1'b1; pixel_in = 8'd6;
    cycle();
    frame_done = 1'b0; pixel_valid = 1'b0;
    checks++; if (stats_valid !== 1'b1) begin errors++; $display("FAIL t5_valid got %0b exp 1", stats_valid); end
    checks++; if (pix_count !== 16'd2 || pix_sum !== 24'd11) begin errors++; $display("FAIL t5_count got %0d/%0d exp 2/11", pix_count, pix_sum); end
    checks++; if (pix_min !== 8'd5 || pix_max !== 8'd6 || bright_count !== 16'd1) begin errors++; $display("FAIL t5_minmax got %0d/%0d/%0d exp 5/6/1", pix_min, pix_max, bright_count); end
    cycle();
  endtask

  task automatic test_back_to_back();
    stats_ready = 1'b0;
    start_frame(8'd0);
    send_pixel(8'd4);
    end_frame();
    start_frame(8'd0);
    send_pixel(8'd9);
    frame_done = 1'b1; frame_start = 1'b1; stats_ready = 1'b1;
    cycle();
    frame_done = 1'b0; frame_start = 1'b0;
    checks++; if (stats_valid !== 1'b1 || pix_sum !== 24'd9) begin errors++; $display("FAIL b2b_load got %0b/%0d exp 1/9", stats_valid, pix_sum); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %0b exp 0", overrun); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b exp 1", busy); end
    end_frame();
    checks++; if (stats_valid !== 1'b1 || pix_count !== 16'd0 || pix_min !== 8'hFF) begin errors++; $display("FAIL b2b_empty got %0b/%0d/%0h exp 1/0/ff", stats_valid, pix_count, pix_min); end
    cycle();
  endtask

  task automatic test_reset_mid_frame();
    stats_ready = 1'b0;
    start_frame(8'd0);
    send_pixel(8'd9);
    end_frame();
    start_frame(8'd0);
    send_pixel(8'd50);
    rst_n = 1'b0;
    #2;
    checks++; if ({stats_valid, busy, overrun, saturated} !== 4'b0000) begin errors++; $display("FAIL t6_flags got %b exp 0000", {stats_valid, busy, overrun, saturated}); end
    checks++; if ({pix_count, pix_sum, pix_min, pix_max, bright_count} !== 72'd0) begin errors++; $display("FAIL t6_fields got %0h exp 0", {pix_count, pix_sum, pix_min, pix_max, bright_count}); end
    cycle();
    rst_n = 1'b1;
    stats_ready = 1'b1;
    cycle();
    start_frame(8'd0);
    send_pixel(8'd7);
    send_pixel(8'd8);
    end_frame();
    checks++; if (pix_count !== 16'd2 || pix_sum !== 24'd15) begin errors++; $display("FAIL t6_count got %0d/%0d exp 2/15", pix_count, pix_sum); end
    checks++; if (pix_min !== 8'd7 || pix_max !== 8'd8 || bright_count !== 16'd2) begin errors++; $display("FAIL t6_minmax got %0d/%0d/%0d exp 7/8/2", pix_min, pix_max, bright_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t6_overrun got %0b exp 0", overrun); end
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_empty();
    test_saturation();
    test_restart();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
